// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, register file geometry and
// the state encoding of the write-port starvation FSM.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BUBBLE
    } starve_state_e;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Signal bundle between WB, the multicycle unit, ID hazard control,
// the RegFile write port and the write-port arbiter.
interface regfile_wport_arbiter_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    import riscv_pkg::*;

    logic                 wb_regwrite;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]      wb_data;

    logic                 mc_issue;
    logic [REG_IDX_W-1:0] mc_issue_rd;
    logic                 mc_valid;
    logic [REG_IDX_W-1:0] mc_rd;
    logic [XLEN-1:0]      mc_data;
    logic                 mc_ready;

    logic                 id_valid;
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic [REG_IDX_W-1:0] id_rd;
    logic                 id_is_mc;
    logic                 stall_id;
    logic                 bubble_req;

    logic                 rf_regwrite;
    logic [REG_IDX_W-1:0] rf_rd;
    logic [XLEN-1:0]      rf_write_data;
    logic                 sb_overflow;

    modport master (
        output wb_regwrite, wb_rd, wb_data,
        output mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
        input  mc_ready,
        output id_valid, id_rs1, id_rs2, id_rd, id_is_mc,
        input  stall_id, bubble_req,
        input  rf_regwrite, rf_rd, rf_write_data, sb_overflow
    );

    modport slave (
        input  wb_regwrite, wb_rd, wb_data,
        input  mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
        output mc_ready,
        input  id_valid, id_rs1, id_rs2, id_rd, id_is_mc,
        output stall_id, bubble_req,
        output rf_regwrite, rf_rd, rf_write_data, sb_overflow
    );

endinterface

// File: rtl/regfile_wport_arbiter_scoreboard.sv
// Pending-destination scoreboard for multicycle ops: pending bits,
// in-flight counter, sticky overflow flag and ID-stage hazard compare.
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mc_issue,
    input  logic [REG_IDX_W-1:0] mc_issue_rd,
    input  logic                 mc_fire,
    input  logic [REG_IDX_W-1:0] mc_rd,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_is_mc,
    output logic                 stall_id,
    output logic                 sb_overflow
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_n;
    logic [OW-1:0]       out_q;
    logic [OW-1:0]       out_n;
    logic                ovf_q;
    logic                full;
    logic                issue_ok;
    logic                haz_rs1;
    logic                haz_rs2;
    logic                haz_rd;

    assign full     = (out_q == OW'(MAX_OUTSTANDING));
    assign issue_ok = mc_issue && !full;

    // Next pending set: completion clears first so a same-cycle issue wins.
    always_comb begin
        pending_n = pending_q;
        if (mc_fire) begin
            pending_n[mc_rd] = 1'b0;
        end
        if (issue_ok && (mc_issue_rd != '0)) begin
            pending_n[mc_issue_rd] = 1'b1;
        end
    end

    // In-flight count: issue and completion cancel, never wraps below zero.
    always_comb begin
        out_n = out_q;
        if (issue_ok && !mc_fire) begin
            out_n = out_q + OW'(1);
        end else if (mc_fire && !issue_ok && (out_q != '0)) begin
            out_n = out_q - OW'(1);
        end
    end

    // Scoreboard state; overflow stays latched until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_n;
            out_q     <= out_n;
            ovf_q     <= ovf_q | (mc_issue && full);
        end
    end

    assign haz_rs1 = pending_q[id_rs1] && (id_rs1 != '0);
    assign haz_rs2 = pending_q[id_rs2] && (id_rs2 != '0);
    assign haz_rd  = pending_q[id_rd] && (id_rd != '0);

    assign stall_id    = id_valid &&
                         (haz_rs1 || haz_rs2 || haz_rd ||
                          (id_is_mc && full));
    assign sb_overflow = ovf_q;

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Single RegFile write port shared by WB (fixed priority) and the
// multicycle completion port, with a starvation bubble request.
module regfile_wport_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN            = riscv_pkg::XLEN,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input logic                    clk,
    input logic                    reset,
    regfile_wport_arbiter_if.slave bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic                 wb_act;
    logic                 mc_fire;
    logic                 blocked;
    logic                 rf_we;
    logic [REG_IDX_W-1:0] rf_rd;
    logic [XLEN-1:0]      rf_wd;

    starve_state_e        state_q;
    starve_state_e        state_n;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_n;
    logic                 bub_q;
    logic                 bub_n;

    assign wb_act  = bus.wb_regwrite && (bus.wb_rd != '0);
    assign mc_fire = bus.mc_valid && !wb_act;
    assign blocked = bus.mc_valid && wb_act;

    // Write-port mux: WB first, then a completing multicycle result.
    always_comb begin
        rf_we = 1'b0;
        rf_rd = '0;
        rf_wd = '0;
        if (wb_act) begin
            rf_we = 1'b1;
            rf_rd = bus.wb_rd;
            rf_wd = bus.wb_data;
        end else if (mc_fire) begin
            rf_we = (bus.mc_rd != '0);
            rf_rd = bus.mc_rd;
            rf_wd = bus.mc_data;
        end
    end

    assign bus.mc_ready      = !wb_act;
    assign bus.rf_regwrite   = rf_we;
    assign bus.rf_rd         = rf_rd;
    assign bus.rf_write_data = rf_wd;

    regfile_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .mc_issue    (bus.mc_issue),
        .mc_issue_rd (bus.mc_issue_rd),
        .mc_fire     (mc_fire),
        .mc_rd       (bus.mc_rd),
        .id_valid    (bus.id_valid),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_rd       (bus.id_rd),
        .id_is_mc    (bus.id_is_mc),
        .stall_id    (bus.stall_id),
        .sb_overflow (bus.sb_overflow)
    );

    // Starvation state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bub_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bub_q   <= bub_n;
        end
    end

    // Count consecutive blocked cycles; any non-blocked cycle resets.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bub_n   = bub_q;
        unique case (state_q)
            IDLE: begin
                cnt_n = '0;
                bub_n = 1'b0;
                if (blocked) begin
                    cnt_n = CW'(1);
                    if (STARVE_LIMIT <= 1) begin
                        state_n = BUBBLE;
                        bub_n   = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!blocked) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    bub_n   = 1'b0;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                    if (cnt_n == CW'(STARVE_LIMIT)) begin
                        state_n = BUBBLE;
                        bub_n   = 1'b1;
                    end
                end
            end
            BUBBLE: begin
                if (!blocked) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    bub_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                bub_n   = 1'b0;
            end
        endcase
    end

    assign bus.bubble_req = bub_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Randomized and directed bench for regfile_wport_arbiter against a
// behavioural model of the write port, scoreboard and starvation rule.
module tb_regfile_wport_arbiter;
    import riscv_pkg::*;

    localparam int MAXO = 4;
    localparam int LIM  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wport_arbiter_if #(.XLEN(32)) bus ();

    regfile_wport_arbiter #(
        .XLEN            (32),
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (LIM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    bit [31:0] m_pend;
    int        m_out;
    bit        m_ovf;
    int        m_run;
    bit        m_bub;

    task automatic chk1(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk5(string name, logic [4:0] act, logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.wb_regwrite = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.mc_issue    = 1'b0;
        bus.mc_issue_rd = '0;
        bus.mc_valid    = 1'b0;
        bus.mc_rd       = '0;
        bus.mc_data     = '0;
        bus.id_valid    = 1'b0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rd       = '0;
        bus.id_is_mc    = 1'b0;
    endtask

    // Model state advance at each clock edge.
    always @(posedge clk) begin
        bit wa, fire, iss, blk;
        if (reset) begin
            m_pend = '0;
            m_out  = 0;
            m_ovf  = 1'b0;
            m_run  = 0;
            m_bub  = 1'b0;
        end else begin
            wa   = bus.wb_regwrite && (bus.wb_rd != 0);
            fire = bus.mc_valid && !wa;
            blk  = bus.mc_valid && wa;
            iss  = bus.mc_issue && (m_out < MAXO);
            if (bus.mc_issue && m_out == MAXO) m_ovf = 1'b1;
            if (fire) m_pend[bus.mc_rd] = 1'b0;
            if (iss && bus.mc_issue_rd != 0) m_pend[bus.mc_issue_rd] = 1'b1;
            if (iss && !fire) m_out = m_out + 1;
            else if (fire && !iss && m_out > 0) m_out = m_out - 1;
            m_run = blk ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
            m_bub = (m_run >= LIM);
        end
    end

    // Every cycle: compare all DUT outputs against the model.
    always @(negedge clk) begin
        bit        wa, fire, st, e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        #2;
        if (checking) begin
            wa   = bus.wb_regwrite && (bus.wb_rd != 0);
            fire = bus.mc_valid && !wa;
            e_we = 1'b0;
            e_rd = '0;
            e_wd = '0;
            if (wa) begin
                e_we = 1'b1;
                e_rd = bus.wb_rd;
                e_wd = bus.wb_data;
            end else if (fire) begin
                e_we = (bus.mc_rd != 0);
                e_rd = bus.mc_rd;
                e_wd = bus.mc_data;
            end
            st = bus.id_valid &&
                 ((m_pend[bus.id_rs1] && bus.id_rs1 != 0) ||
                  (m_pend[bus.id_rs2] && bus.id_rs2 != 0) ||
                  (m_pend[bus.id_rd] && bus.id_rd != 0) ||
                  (bus.id_is_mc && m_out == MAXO));
            chk1("m_mc_ready", bus.mc_ready, !wa);
            chk1("m_rf_we", bus.rf_regwrite, e_we);
            chk5("m_rf_rd", bus.rf_rd, e_rd);
            chk32("m_rf_wd", bus.rf_write_data, e_wd);
            chk1("m_stall", bus.stall_id, st);
            chk1("m_bubble", bus.bubble_req, m_bub);
            chk1("m_ovf", bus.sb_overflow, m_ovf);
        end
    end

    task automatic starve(int n, logic [4:0] rd);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            idle();
            bus.wb_regwrite = 1'b1;
            bus.wb_rd       = 5'd1;
            bus.wb_data     = $urandom;
            bus.mc_valid    = 1'b1;
            bus.mc_rd       = rd;
            bus.mc_data     = 32'h0000_BEEF;
            #3;
            chk1("starve_bub", bus.bubble_req, (i > LIM) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic issue(logic [4:0] rd);
        @(negedge clk);
        idle();
        bus.mc_issue    = 1'b1;
        bus.mc_issue_rd = rd;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        checking = 1'b1;
        @(posedge clk);

        @(negedge clk);
        reset = 1'b0;
        bus.id_valid = 1'b1;
        bus.id_is_mc = 1'b1;
        #3;
        chk1("rst_stall", bus.stall_id, 1'b0);
        chk1("rst_bub", bus.bubble_req, 1'b0);
        chk1("rst_ovf", bus.sb_overflow, 1'b0);
        chk1("rst_we", bus.rf_regwrite, 1'b0);

        // Write-port conflict: WB wins, multicycle result next cycle.
        @(negedge clk);
        idle();
        bus.wb_regwrite = 1'b1;
        bus.wb_rd       = 5'd5;
        bus.wb_data     = 32'h0000_AAAA;
        bus.mc_valid    = 1'b1;
        bus.mc_rd       = 5'd7;
        bus.mc_data     = 32'h0000_1234;
        #3;
        chk5("arb_rd_wb", bus.rf_rd, 5'd5);
        chk32("arb_wd_wb", bus.rf_write_data, 32'h0000_AAAA);
        chk1("arb_rdy_wb", bus.mc_ready, 1'b0);
        @(negedge clk);
        bus.wb_regwrite = 1'b0;
        #3;
        chk1("arb_we_mc", bus.rf_regwrite, 1'b1);
        chk5("arb_rd_mc", bus.rf_rd, 5'd7);
        chk32("arb_wd_mc", bus.rf_write_data, 32'h0000_1234);
        chk1("arb_rdy_mc", bus.mc_ready, 1'b1);

        // RAW hazard on x9, x0 never stalls.
        issue(5'd9);
        @(negedge clk);
        idle();
        bus.id_valid    = 1'b1;
        bus.id_rs1      = 5'd9;
        bus.mc_issue    = 1'b1;
        bus.mc_issue_rd = 5'd0;
        #3;
        chk1("raw_stall", bus.stall_id, 1'b1);
        @(negedge clk);
        idle();
        bus.id_valid = 1'b1;
        #3;
        chk1("raw_x0", bus.stall_id, 1'b0);
        @(negedge clk);
        idle();
        bus.id_valid = 1'b1;
        bus.id_rs1   = 5'd9;
        bus.mc_valid = 1'b1;
        bus.mc_rd    = 5'd9;
        bus.mc_data  = 32'h0000_0099;
        #3;
        chk1("raw_same_cyc", bus.stall_id, 1'b1);
        @(negedge clk);
        idle();
        bus.id_valid = 1'b1;
        bus.id_rs1   = 5'd9;
        #3;
        chk1("raw_release", bus.stall_id, 1'b0);
        @(negedge clk);
        idle();
        bus.mc_valid = 1'b1;
        bus.mc_rd    = 5'd0;
        #3;
        chk1("mc_x0_we", bus.rf_regwrite, 1'b0);

        // Set-wins collision on x3, then fill to capacity.
        issue(5'd3);
        @(negedge clk);
        idle();
        bus.mc_issue    = 1'b1;
        bus.mc_issue_rd = 5'd3;
        bus.mc_valid    = 1'b1;
        bus.mc_rd       = 5'd3;
        issue(5'd10);
        bus.id_valid = 1'b1;
        bus.id_rs2   = 5'd3;
        #3;
        chk1("setwins", bus.stall_id, 1'b1);
        issue(5'd11);
        issue(5'd12);
        @(negedge clk);
        idle();
        bus.id_valid    = 1'b1;
        bus.id_is_mc    = 1'b1;
        bus.mc_issue    = 1'b1;
        bus.mc_issue_rd = 5'd13;
        #3;
        chk1("cap_stall", bus.stall_id, 1'b1);
        chk1("cap_no_ovf", bus.sb_overflow, 1'b0);
        @(negedge clk);
        idle();
        bus.id_valid = 1'b1;
        bus.id_is_mc = 1'b1;
        #3;
        chk1("cap_ovf", bus.sb_overflow, 1'b1);
        chk1("cap_stall2", bus.stall_id, 1'b1);
        @(negedge clk);
        bus.mc_valid = 1'b1;
        bus.mc_rd    = 5'd10;
        #3;
        chk1("cap_stall3", bus.stall_id, 1'b1);
        @(negedge clk);
        idle();
        bus.id_valid = 1'b1;
        bus.id_is_mc = 1'b1;
        #3;
        chk1("cap_free", bus.stall_id, 1'b0);
        chk1("ovf_sticky", bus.sb_overflow, 1'b1);

        // Reset mid-operation with two in flight and a bubble raised.
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        issue(5'd4);
        issue(5'd5);
        starve(LIM + 1, 5'd4);
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.id_valid = 1'b1;
        bus.id_rs1   = 5'd4;
        bus.id_rs2   = 5'd5;
        bus.id_is_mc = 1'b1;
        #3;
        chk1("rst2_stall", bus.stall_id, 1'b0);
        chk1("rst2_bub", bus.bubble_req, 1'b0);
        chk1("rst2_ovf", bus.sb_overflow, 1'b0);
        @(negedge clk);
        idle();
        bus.mc_valid = 1'b1;
        bus.mc_rd    = 5'd4;
        bus.mc_data  = 32'h0000_4444;
        #3;
        chk5("late_rd", bus.rf_rd, 5'd4);
        chk32("late_wd", bus.rf_write_data, 32'h0000_4444);

        // Starvation, then one idle WB cycle releases the bubble.
        starve(LIM + 1, 5'd6);
        @(negedge clk);
        idle();
        bus.mc_valid = 1'b1;
        bus.mc_rd    = 5'd6;
        #3;
        chk1("rel_ready", bus.mc_ready, 1'b1);
        chk1("rel_bub_hold", bus.bubble_req, 1'b1);
        @(negedge clk);
        idle();
        #3;
        chk1("rel_bub_clr", bus.bubble_req, 1'b0);

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 4000; n++) begin
            int ph;
            ph = (n / 100) % 4;
            @(negedge clk);
            reset           = ($urandom_range(0, 249) == 0);
            bus.wb_regwrite = (ph == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.wb_rd       = (ph == 3) ? 5'($urandom_range(1, 31))
                                        : 5'($urandom_range(0, 7));
            bus.wb_data     = $urandom;
            bus.mc_issue    = ($urandom_range(0, 9) < 3);
            bus.mc_issue_rd = 5'($urandom_range(0, 15));
            bus.mc_valid    = (ph == 3) ? 1'b1 : ($urandom_range(0, 9) < 4);
            bus.mc_rd       = 5'($urandom_range(0, 15));
            bus.mc_data     = $urandom;
            bus.id_valid    = 1'($urandom_range(0, 1));
            bus.id_rs1      = 5'($urandom_range(0, 15));
            bus.id_rs2      = 5'($urandom_range(0, 15));
            bus.id_rd       = 5'($urandom_range(0, 15));
            bus.id_is_mc    = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        idle();
        reset = 1'b0;
        @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
